// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU-side RAM bus sequencer.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StPhaseHi,
      StPhaseLo,
      StDone
   } state_e;

   localparam int unsigned RAM_SIZE      = 256;
   localparam logic [7:0]  UNMAPPED_DATA = 8'hFF;

   // True when the byte address falls inside the RAM window starting at base.
   function automatic logic in_window(input logic [15:0] a, input logic [15:0] base);
      logic [15:0] off;
      off = a - base;
      return {16'h0000, off} < RAM_SIZE;
   endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// Byte/word request sequencer driving the 256-byte sync-write RAM with
// programmable wait states; unmapped phases complete with error and 8'hFF.
module mem_bus_ctrl
   import mem_bus_pkg::*;
#(
   parameter logic [15:0] RAM_BASE    = 16'h0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        word,
   input  logic        wr,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic        ready,
   output logic        ack,
   output logic        err,
   output logic [15:0] rdata,
   output logic        ram_sel,
   output logic        ram_wr_n,
   output logic [7:0]  ram_a,
   output logic [7:0]  ram_din,
   input  logic [7:0]  ram_dout
);

   localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        word_q, wr_q;
   logic [15:0] addr_q, wdata_q;
   logic [7:0]  hi_q, hi_d;
   logic        err_acc_q, err_acc_d;
   logic        ack_d, err_d;
   logic [15:0] rdata_d;
   logic        ram_sel_d, ram_wr_n_d;
   logic [7:0]  ram_a_d, ram_din_d;

   logic        accept;
   logic [15:0] cur_a;
   logic        cur_mapped;
   logic [7:0]  phase_byte;
   logic        last;

   assign ready      = (state_q == StIdle);
   assign accept     = ready && req;
   assign cur_a      = (state_q == StPhaseLo) ? addr_q + 16'd1 : addr_q;
   assign cur_mapped = in_window(cur_a, RAM_BASE);
   assign phase_byte = cur_mapped ? ram_dout : UNMAPPED_DATA;
   assign last       = (cnt_q == 4'd0);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      err_acc_d = err_acc_q;
      rdata_d   = rdata;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               state_d   = StPhaseHi;
               cnt_d     = WaitInit;
               err_acc_d = 1'b0;
            end
         end
         StPhaseHi: begin
            if (!last) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               hi_d      = phase_byte;
               err_acc_d = err_acc_q | ~cur_mapped;
               if (word_q) begin
                  state_d = StPhaseLo;
                  cnt_d   = WaitInit;
               end else begin
                  state_d = StDone;
                  ack_d   = 1'b1;
                  err_d   = err_acc_q | ~cur_mapped;
                  if (!wr_q) rdata_d = {8'h00, phase_byte};
               end
            end
         end
         StPhaseLo: begin
            if (!last) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = StDone;
               ack_d   = 1'b1;
               err_d   = err_acc_q | ~cur_mapped;
               if (!wr_q) rdata_d = {hi_q, phase_byte};
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // RAM pins are registered, so they are derived from the upcoming state/count.
   logic [15:0] nxt_base, nxt_a, nxt_wdata;
   logic        nxt_word, nxt_wr, nxt_phase;

   always_comb begin
      nxt_base   = ready ? addr  : addr_q;
      nxt_wdata  = ready ? wdata : wdata_q;
      nxt_word   = ready ? word  : word_q;
      nxt_wr     = ready ? wr    : wr_q;
      nxt_phase  = (state_d == StPhaseHi) || (state_d == StPhaseLo);
      nxt_a      = (state_d == StPhaseLo) ? nxt_base + 16'd1 : nxt_base;
      ram_sel_d  = nxt_phase && in_window(nxt_a, RAM_BASE);
      ram_wr_n_d = !(ram_sel_d && nxt_wr && (cnt_d == 4'd0));
      ram_a_d    = nxt_phase ? nxt_a[7:0] : ram_a;
      ram_din_d  = ram_din;
      if (nxt_phase) begin
         ram_din_d = (state_d == StPhaseHi && nxt_word) ? nxt_wdata[15:8] : nxt_wdata[7:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         word_q    <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= 16'h0000;
         wdata_q   <= 16'h0000;
         hi_q      <= 8'h00;
         err_acc_q <= 1'b0;
         ack       <= 1'b0;
         err       <= 1'b0;
         rdata     <= 16'h0000;
         ram_sel   <= 1'b0;
         ram_wr_n  <= 1'b1;
         ram_a     <= 8'h00;
         ram_din   <= 8'h00;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         err_acc_q <= err_acc_d;
         ack       <= ack_d;
         err       <= err_d;
         rdata     <= rdata_d;
         ram_sel   <= ram_sel_d;
         ram_wr_n  <= ram_wr_n_d;
         ram_a     <= ram_a_d;
         ram_din   <= ram_din_d;
         if (accept) begin
            word_q  <= word;
            wr_q    <= wr;
            addr_q  <= addr;
            wdata_q <= wdata;
         end
      end
   end

endmodule
